// File: rtl/route_sched_pkg.sv
// route_sched_pkg: shared types and command encodings for the route scheduler.
//   rs_state_t : scheduler FSM state
//   CMD_GO_OP  : opcode bits placed above the destination in a go command
//   CMD_STOP   : stop command byte
package route_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_GO,
        S_WAIT_MOVE,
        S_TRANSIT,
        S_DWELL,
        S_ISSUE_STOP
    } rs_state_t;

    localparam logic [1:0] CMD_GO_OP = 2'b01;
    localparam logic [7:0] CMD_STOP  = 8'h00;

    function automatic logic [7:0] go_cmd(input logic [5:0] dest);
        return {CMD_GO_OP, dest};
    endfunction

endpackage

// File: rtl/route_sched_fifo.sv
// dest_fifo: synchronous FIFO holding queued destination IDs.
//   clk, rst_n : clock, async active-low reset
//   push       : write push_data (dropped when full unless a pop happens too)
//   push_data  : entry to write
//   pop        : remove head entry (ignored when empty)
//   flush      : empty the queue; a same-cycle push or pop is discarded
//   head       : current head entry (valid when !empty)
//   full/empty : occupancy flags
//   count      : occupancy, 0..DEPTH
module dest_fifo
    import route_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_nxt;

    assign empty     = (count == '0);
    assign do_pop    = pop && !empty && !flush;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign do_push   = push && !flush && (!full || do_pop);
    assign count_nxt = count + CW'(do_push) - CW'(do_pop);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/route_sched.sv
// route_sched: issues queued destination stations one at a time as go
// commands, follows in_transit for departure/arrival, dwells, then moves on.
// An abort flushes the route and issues a stop command.
//   clk, rst_n   : clock, async active-low reset
//   wr_en/wr_dest: queue a destination
//   abort        : flush route and stop
//   clr_cmd_rdy  : consumer has taken cmd
//   in_transit   : robot is moving
//   cmd/cmd_rdy  : pending command byte and its valid flag
//   cur_dest     : destination being served
//   count/full   : queue occupancy
//   busy         : not idle
//   overflow, arrived, no_start, route_done : single-cycle event pulses
//
// state        | meaning
// S_IDLE       | waiting for a queued destination
// S_ISSUE_GO   | go command raised, waiting for the consumer to take it
// S_WAIT_MOVE  | go taken, waiting for in_transit to rise (with timeout)
// S_TRANSIT    | moving, waiting for in_transit to fall
// S_DWELL      | stopped at the station for DWELL_CYCLES clocks
// S_ISSUE_STOP | stop command pending after an abort
module route_sched
    import route_sched_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int DWELL_CYCLES  = 1000,
    parameter int START_TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [5:0]               wr_dest,
    input  logic                     abort,
    input  logic                     clr_cmd_rdy,
    input  logic                     in_transit,
    output logic [7:0]               cmd,
    output logic                     cmd_rdy,
    output logic [5:0]               cur_dest,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     busy,
    output logic                     overflow,
    output logic                     arrived,
    output logic                     no_start,
    output logic                     route_done
);

    localparam int TMAX = (DWELL_CYCLES > START_TIMEOUT) ? DWELL_CYCLES : START_TIMEOUT;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] START_LOAD = TW'(START_TIMEOUT - 1);

    rs_state_t   state;
    logic [TW-1:0] timer;
    logic        abort_take;
    logic        fifo_pop;
    logic        fifo_empty;
    logic [5:0]  fifo_head;

    // A second abort while the stop is still pending has nothing left to do.
    assign abort_take = abort && (state != S_ISSUE_STOP);
    assign fifo_pop   = (state == S_IDLE) && !fifo_empty && !abort_take;

    dest_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (6)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_dest),
        .pop       (fifo_pop),
        .flush     (abort_take),
        .head      (fifo_head),
        .full      (full),
        .empty     (fifo_empty),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            cmd        <= CMD_STOP;
            cmd_rdy    <= 1'b0;
            cur_dest   <= '0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            arrived    <= 1'b0;
            no_start   <= 1'b0;
            route_done <= 1'b0;
        end else begin
            arrived    <= 1'b0;
            no_start   <= 1'b0;
            route_done <= 1'b0;
            // A write racing an abort is discarded silently, not reported.
            overflow   <= wr_en && !abort_take && full && !fifo_pop;

            if (abort_take) begin
                // Replaces any pending go in place; a go taken on this same
                // edge is simply followed by the stop.
                state   <= S_ISSUE_STOP;
                cmd     <= CMD_STOP;
                cmd_rdy <= 1'b1;
                busy    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!fifo_empty) begin
                            cur_dest <= fifo_head;
                            state    <= S_ISSUE_GO;
                            busy     <= 1'b1;
                        end
                    end
                    S_ISSUE_GO: begin
                        if (!cmd_rdy) begin
                            cmd     <= go_cmd(cur_dest);
                            cmd_rdy <= 1'b1;
                        end else if (clr_cmd_rdy) begin
                            cmd_rdy <= 1'b0;
                            timer   <= START_LOAD;
                            state   <= S_WAIT_MOVE;
                        end
                    end
                    S_WAIT_MOVE: begin
                        if (in_transit) begin
                            state <= S_TRANSIT;
                        end else if (timer == '0) begin
                            // Never left: typically already at this station.
                            no_start <= 1'b1;
                            timer    <= DWELL_LOAD;
                            state    <= S_DWELL;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    S_TRANSIT: begin
                        if (!in_transit) begin
                            arrived <= 1'b1;
                            timer   <= DWELL_LOAD;
                            state   <= S_DWELL;
                        end
                    end
                    S_DWELL: begin
                        if (timer == '0) begin
                            route_done <= fifo_empty;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    S_ISSUE_STOP: begin
                        if (cmd_rdy && clr_cmd_rdy) begin
                            cmd_rdy <= 1'b0;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                    default: begin
                        cmd_rdy <= 1'b0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_route_sched.sv
// tb_route_sched: self-checking bench for route_sched. A table of stations
// with their expected command bytes drives the main route; expected commands
// are queued when stimulus is applied and compared when cmd_rdy is seen.
// Hand-written sequences cover overflow, abort and reset corner cases.
module tb_route_sched;
    import route_sched_pkg::*;

    localparam int DEPTH = 8;
    localparam int DWELL = 40;
    localparam int START = 100;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [5:0]    wr_dest = '0;
    logic          abort = 1'b0;
    logic          clr_cmd_rdy = 1'b0;
    logic          in_transit = 1'b0;
    logic [7:0]    cmd;
    logic          cmd_rdy;
    logic [5:0]    cur_dest;
    logic [CW-1:0] count;
    logic          full, busy, overflow, arrived, no_start, route_done;

    route_sched #(
        .DEPTH         (DEPTH),
        .DWELL_CYCLES  (DWELL),
        .START_TIMEOUT (START)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_dest     (wr_dest),
        .abort       (abort),
        .clr_cmd_rdy (clr_cmd_rdy),
        .in_transit  (in_transit),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .cur_dest    (cur_dest),
        .count       (count),
        .full        (full),
        .busy        (busy),
        .overflow    (overflow),
        .arrived     (arrived),
        .no_start    (no_start),
        .route_done  (route_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] dest;
        int         move_len;   // 0: robot never departs
        logic [7:0] exp_cmd;
        logic       exp_arr;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_q [$];
    int         tests = 0;
    int         fails = 0;

    // Event counters, sampled at the clock edge (pre-update values).
    int   n_arr = 0, n_ovf = 0, n_done = 0, n_stop = 0;
    logic prev_stop = 1'b0;
    always @(posedge clk) begin
        if (arrived)    n_arr++;
        if (overflow)   n_ovf++;
        if (route_done) n_done++;
        if (cmd_rdy && cmd == CMD_STOP && !prev_stop) n_stop++;
        prev_stop = cmd_rdy && (cmd == CMD_STOP);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_dest(input logic [5:0] d, input logic [7:0] e);
        wr_en   = 1'b1;
        wr_dest = d;
        exp_q.push_back(e);
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic wait_cmd();
        int k = 0;
        logic [7:0] e;
        while (!cmd_rdy && k < 50) begin
            tick(1);
            k++;
        end
        if (exp_q.size() == 0) e = 8'hFF;
        else e = exp_q.pop_front();
        check("cmd_rdy_seen", 32'(cmd_rdy), 32'd1);
        check("cmd_byte", 32'(cmd), 32'(e));
    endtask

    task automatic ack();
        tick(2);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("cmd_rdy_cleared", 32'(cmd_rdy), 32'd0);
    endtask

    task automatic serve(input vec_t v, input bit last);
        int k;
        wait_cmd();
        ack();
        if (v.move_len > 0) begin
            tick(2);
            check("wait_move_busy", 32'(busy), 32'd1);
            in_transit = 1'b1;
            tick(v.move_len);
            in_transit = 1'b0;
            tick(1);
            check("arrived_pulse", 32'(arrived), 32'(v.exp_arr));
        end else begin
            k = 0;
            while (!no_start && k < START + 20) begin
                tick(1);
                k++;
            end
            check("no_start_latency", 32'(k), 32'(START));
        end
        k = 0;
        while (busy && k < DWELL + 20) begin
            tick(1);
            k++;
        end
        check("dwell_len", 32'(k), 32'(DWELL));
        check("route_done", 32'(route_done), 32'(last));
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({cmd, cmd_rdy, cur_dest, count, full, busy,
                    overflow, arrived, no_start, route_done});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int s_arr, s_ovf, s_done, s_stop;

    initial begin
        vecs[0] = '{6'd5,  50, 8'h45, 1'b1};
        vecs[1] = '{6'd9,  50, 8'h49, 1'b1};
        vecs[2] = '{6'd3,  50, 8'h43, 1'b1};
        vecs[3] = '{6'd7,  0,  8'h47, 1'b0};
        vecs[4] = '{6'd63, 1,  8'h7F, 1'b1};

        #2 rst_n = 1'b0;
        tick(2);
        check("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Main route: three stations queued back to back, served in order.
        s_arr = n_arr; s_done = n_done; s_stop = n_stop;
        for (int i = 0; i < 3; i++) push_dest(vecs[i].dest, vecs[i].exp_cmd);
        check("queued_count", 32'(count), 32'd2);
        check("first_cur_dest", 32'(cur_dest), 32'd5);
        for (int i = 0; i < 3; i++) serve(vecs[i], i == 2);
        tick(2);
        check("route_count_end", 32'(count), 32'd0);
        check("route_arrivals", 32'(n_arr - s_arr), 32'd3);
        check("route_done_once", 32'(n_done - s_done), 32'd1);

        // Single station that never departs; also the pop/issue latency.
        push_dest(vecs[3].dest, vecs[3].exp_cmd);
        check("lat_count_n", 32'(count), 32'd1);
        check("lat_rdy_n", 32'(cmd_rdy), 32'd0);
        tick(1);
        check("lat_busy_n1", 32'(busy), 32'd1);
        check("lat_dest_n1", 32'(cur_dest), 32'd7);
        check("lat_count_n1", 32'(count), 32'd0);
        check("lat_rdy_n1", 32'(cmd_rdy), 32'd0);
        serve(vecs[3], 1'b1);
        tick(2);
        check("nostart_no_stop", 32'(n_stop - s_stop), 32'd0);

        // Overflow while the scheduler is held in ISSUE_GO.
        s_ovf = n_ovf; s_stop = n_stop;
        push_dest(6'd10, 8'h4A);
        wait_cmd();
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_en   = 1'b1;
            wr_dest = 6'(20 + i);
            tick(1);
        end
        wr_en = 1'b0;
        check("ovf_count", 32'(count), 32'(DEPTH));
        check("ovf_full", 32'(full), 32'd1);
        tick(2);
        check("ovf_pulses", 32'(n_ovf - s_ovf), 32'd2);
        // Abort with a write racing it on a full queue.
        wr_en = 1'b1; wr_dest = 6'd40; abort = 1'b1;
        exp_q.delete(); exp_q.push_back(CMD_STOP);
        tick(1);
        wr_en = 1'b0; abort = 1'b0;
        check("abort_full_count", 32'(count), 32'd0);
        check("abort_full_flag", 32'(full), 32'd0);
        check("abort_replace_rdy", 32'(cmd_rdy), 32'd1);
        wait_cmd();
        ack();
        check("abort_idle", 32'(busy), 32'd0);
        tick(2);
        check("abort_no_ovf", 32'(n_ovf - s_ovf), 32'd2);
        check("abort_one_stop", 32'(n_stop - s_stop), 32'd1);

        // Abort mid-transit with three entries queued behind.
        s_arr = n_arr; s_done = n_done; s_stop = n_stop;
        push_dest(6'd11, 8'h4B);
        wait_cmd();
        ack();
        tick(2);
        in_transit = 1'b1;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_dest = 6'(12 + i);
            tick(1);
        end
        wr_en = 1'b0;
        check("transit_queued", 32'(count), 32'd3);
        abort = 1'b1;
        exp_q.delete(); exp_q.push_back(CMD_STOP);
        tick(1);
        abort = 1'b0;
        check("transit_abort_cmd", 32'({cmd_rdy, cmd}), 32'h100);
        check("transit_abort_count", 32'(count), 32'd0);
        in_transit = 1'b0;
        wait_cmd();
        ack();
        check("transit_abort_idle", 32'(busy), 32'd0);
        tick(DWELL + 5);
        check("transit_stays_idle", 32'(busy), 32'd0);
        check("transit_no_done", 32'(n_done - s_done), 32'd0);
        check("transit_no_arrive", 32'(n_arr - s_arr), 32'd0);
        check("transit_one_stop", 32'(n_stop - s_stop), 32'd1);

        // Abort together with the acknowledge of a go.
        s_stop = n_stop;
        push_dest(6'd15, 8'h4F);
        wait_cmd();
        clr_cmd_rdy = 1'b1; abort = 1'b1;
        exp_q.delete(); exp_q.push_back(CMD_STOP);
        tick(1);
        clr_cmd_rdy = 1'b0; abort = 1'b0;
        check("ack_abort_cmd", 32'({cmd_rdy, cmd}), 32'h100);
        wait_cmd();
        ack();
        tick(3);
        check("ack_abort_idle", 32'({busy, cmd_rdy}), 32'd0);
        check("ack_abort_one_stop", 32'(n_stop - s_stop), 32'd1);

        // Abort with the go still pending, then a second abort that is ignored.
        s_stop = n_stop;
        push_dest(6'd16, 8'h50);
        wait_cmd();
        abort = 1'b1;
        exp_q.delete(); exp_q.push_back(CMD_STOP);
        tick(1);
        check("pend_abort_cmd", 32'({cmd_rdy, cmd}), 32'h100);
        tick(1);
        abort = 1'b0;
        check("pend_abort_again", 32'({cmd_rdy, cmd}), 32'h100);
        wait_cmd();
        ack();
        tick(3);
        check("pend_abort_idle", 32'({busy, cmd_rdy}), 32'd0);
        check("pend_abort_one_stop", 32'(n_stop - s_stop), 32'd1);

        // Abort in IDLE still issues a stop.
        abort = 1'b1;
        exp_q.delete(); exp_q.push_back(CMD_STOP);
        tick(1);
        abort = 1'b0;
        wait_cmd();
        ack();
        check("idle_abort_done", 32'(busy), 32'd0);

        // Reset during DWELL, then a fresh route.
        s_stop = n_stop; s_done = n_done;
        push_dest(6'd17, 8'h51);
        wait_cmd();
        ack();
        tick(2);
        in_transit = 1'b1;
        tick(5);
        in_transit = 1'b0;
        tick(6);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", all_outs(), 32'd0);
        tick(2);
        rst_n = 1'b1;
        exp_q.delete();
        tick(1);
        push_dest(vecs[4].dest, vecs[4].exp_cmd);
        serve(vecs[4], 1'b1);
        tick(2);
        check("reset_no_stop", 32'(n_stop - s_stop), 32'd0);
        check("reset_route_done", 32'(n_done - s_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
